// File: rtl/mem_access_ctrl.sv
// Memory access controller: arbitrates the fetch and load/store ports onto the 32x16 unified memory.
// Define MEM_CTRL_RR_ARB_EN for round-robin arbitration; otherwise ls has fixed priority over if.
module mem_access_ctrl #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              proc_rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_done,
  input  logic              ls_req,
  input  logic              ls_we,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic [DATA_W-1:0] ls_wdata,
  output logic [DATA_W-1:0] ls_rdata,
  output logic              ls_done,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_in,
  output logic              mem_write,
  output logic              mem_read,
  input  logic [DATA_W-1:0] mem_out,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic              win_ls_q, win_ls_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              write_n_q, write_n_d;
  logic              read_n_q, read_n_d;
  logic              if_done_q, if_done_d;
  logic              ls_done_q, ls_done_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] ls_rdata_q, ls_rdata_d;
  logic              busy_q, busy_d;
  logic              grant_ls_s;

`ifdef MEM_CTRL_RR_ARB_EN
  logic last_ls_q, last_ls_d;

  // Round-robin grant: on a tie the port not granted last wins.
  always_comb begin
    last_ls_d = last_ls_q;
    if (ls_req && if_req) begin
      grant_ls_s = ~last_ls_q;
    end else begin
      grant_ls_s = ls_req;
    end
    if ((state_q == IDLE) && (ls_req || if_req)) begin
      last_ls_d = grant_ls_s;
    end else begin
      last_ls_d = last_ls_q;
    end
  end

  // Last-grant register; starts as ls so the first tie goes to fetch.
  always_ff @(posedge clk or negedge proc_rst) begin
    if (!proc_rst) begin
      last_ls_q <= 1'b1;
    end else begin
      last_ls_q <= last_ls_d;
    end
  end
`else
  // Fixed priority grant: load/store always beats fetch.
  always_comb begin
    grant_ls_s = ls_req;
  end
`endif

  // Next-state and registered-output logic; strobes and done pulses default inactive.
  always_comb begin
    state_d    = state_q;
    win_ls_d   = win_ls_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    write_n_d  = 1'b1;
    read_n_d   = 1'b1;
    if_done_d  = 1'b0;
    ls_done_d  = 1'b0;
    if_rdata_d = if_rdata_q;
    ls_rdata_d = ls_rdata_q;
    busy_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (if_req || ls_req) begin
          state_d   = ACCESS;
          busy_d    = 1'b1;
          win_ls_d  = grant_ls_s;
          we_d      = grant_ls_s & ls_we;
          write_n_d = ~(grant_ls_s & ls_we);
          read_n_d  = grant_ls_s & ls_we;
          if (grant_ls_s) begin
            addr_d  = ls_addr;
            wdata_d = ls_wdata;
          end else begin
            addr_d  = if_addr;
            wdata_d = wdata_q;
          end
        end else begin
          state_d = IDLE;
        end
      end
      ACCESS: begin
        // mem_out was registered by the memory on the negedge inside ACCESS.
        state_d = RESP;
        busy_d  = 1'b1;
        if (win_ls_q) begin
          ls_done_d = 1'b1;
          if (!we_q) begin
            ls_rdata_d = mem_out;
          end else begin
            ls_rdata_d = ls_rdata_q;
          end
        end else begin
          if_done_d  = 1'b1;
          if_rdata_d = mem_out;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; reset aborts any access in flight.
  always_ff @(posedge clk or negedge proc_rst) begin
    if (!proc_rst) begin
      state_q    <= IDLE;
      win_ls_q   <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= {ADDR_W{1'b0}};
      wdata_q    <= {DATA_W{1'b0}};
      write_n_q  <= 1'b1;
      read_n_q   <= 1'b1;
      if_done_q  <= 1'b0;
      ls_done_q  <= 1'b0;
      if_rdata_q <= {DATA_W{1'b0}};
      ls_rdata_q <= {DATA_W{1'b0}};
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      win_ls_q   <= win_ls_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      write_n_q  <= write_n_d;
      read_n_q   <= read_n_d;
      if_done_q  <= if_done_d;
      ls_done_q  <= ls_done_d;
      if_rdata_q <= if_rdata_d;
      ls_rdata_q <= ls_rdata_d;
      busy_q     <= busy_d;
    end
  end

  assign mem_address = addr_q;
  assign mem_in      = wdata_q;
  assign mem_write   = write_n_q;
  assign mem_read    = read_n_q;
  assign if_done     = if_done_q;
  assign ls_done     = ls_done_q;
  assign if_rdata    = if_rdata_q;
  assign ls_rdata    = ls_rdata_q;
  assign busy        = busy_q;

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
Memory access controller that sits directly upstream of the 32x16 unified memory. It arbitrates between the processor's instruction-fetch port and its load/store port. It drives the memory's address, write-data and active-low read/write strobes, and captures the memory's negedge-registered read data. Each completed access is returned to the winning requester with a one-cycle done pulse.

Parameters:
ADDR_W, 5, memory word-address width
DATA_W, 16, memory data width

Ports:
clk  in  1  system clock; all controller state updates on posedge
proc_rst  in  1  asynchronous active-low reset
if_req  in  1  fetch request; held high with if_addr until if_done
if_addr  in  ADDR_W  fetch word address
if_rdata  out  DATA_W  fetched word; valid when if_done=1, held until next fetch completes
if_done  out  1  one-cycle fetch completion pulse
ls_req  in  1  load/store request; held high with ls_we/ls_addr/ls_wdata until ls_done
ls_we  in  1  1=store, 0=load
ls_addr  in  ADDR_W  load/store word address
ls_wdata  in  DATA_W  store data
ls_rdata  out  DATA_W  loaded word; valid when ls_done=1; unchanged by stores
ls_done  out  1  one-cycle load/store completion pulse
mem_address  out  ADDR_W  to memory address
mem_in  out  DATA_W  to memory write data
mem_write  out  1  to memory write strobe, active low
mem_read  out  1  to memory read strobe, active low
mem_out  in  DATA_W  from memory read data, registered by the memory on negedge clk
busy  out  1  high in ACCESS and RESP

Behaviour:
- Reset (proc_rst=0, asynchronous):
  - state=IDLE; mem_write=1, mem_read=1.
  - mem_address=0, mem_in=0; if_done=0, ls_done=0; if_rdata=0, ls_rdata=0; busy=0.
  - Reset during an access aborts it immediately: strobes go inactive at once and no done pulse is issued.
- FSM:
  - IDLE -> ACCESS on any request. At the grant edge, latch the winner's address, we and wdata into mem_address/mem_in/hold regs, and record the winner.
  - ACCESS lasts exactly one cycle:
    - store: mem_write=0, mem_read=1.
    - load or fetch: mem_read=0, mem_write=1.
    - Address and data stay stable across the negedge on which the memory samples.
  - ACCESS -> RESP at the next posedge:
    - strobes return high.
    - for reads, capture mem_out into the winner's rdata register.
    - winner's done=1 during RESP.
  - RESP -> IDLE unconditionally. Requests are ignored in RESP, so a requester dropping req on done never triggers a re-issue.
- Latency: request seen at posedge N; done high in cycle N+2; rdata valid in that same cycle. Peak throughput is one access per 3 cycles.
- Arbitration (default): fixed priority, ls over if. Fetch stalls while ls_req is high in IDLE.
- Requester inputs are sampled only at the grant edge. Changes during ACCESS/RESP have no effect, and a withdrawn req still receives its done pulse.
- mem_address/mem_in hold their last value outside ACCESS. Strobes are never both low.
- Addresses use the full ADDR_W range; there is no out-of-range check.

Optional Feature:
MEM_CTRL_RR_ARB_EN
- Defined: round-robin arbitration. A last_grant register (reset value = ls) gives the tie to the port not granted last. With both ports requesting continuously, grants alternate if, ls, if, ...
- Undefined: fixed ls-over-if priority as above; no last_grant register.

Test Plan:
- Reset, then ls_req=1, ls_we=1, ls_addr=5, ls_wdata=16'hA5A5 -> mem_write low for exactly one cycle with mem_address=5; ls_done pulses 2 cycles after the request; a follow-up load of addr 5 returns ls_rdata=16'hA5A5.
- Fetch if_addr=1 after memory init -> mem_read low one cycle; if_done pulses with if_rdata=16'b0010001011101000; ls_rdata unchanged.
- if_req and ls_req (load addr 2) raised in the same cycle -> ls served first (ls_rdata=16'b0000001011100010), then if served; no cycle with both strobes low.
- Same as the previous scenario with MEM_CTRL_RR_ARB_EN defined and both reqs held for 4 accesses -> grant order if, ls, if, ls.
- proc_rst pulsed low during ACCESS of a store -> mem_write high immediately; no ls_done; all outputs at reset values; a fresh request afterwards completes normally.
- Requester holds req high through RESP -> exactly one access and one done pulse per request, with re-issue only after passing through IDLE.
